mux4reg_rr_ctrl: RTL and testbench

Round-robin controller that shares one registered 4:1 data mux between four requesters. It selects a winner, drives the mux select, and presents the registered word to a single consumer with a valid/ready handshake. It acknowledges the winning requester on hand-off. It sits in front of the registered-mux datapath and replaces hard-wired select logic.

---
 rtl/mux4reg_rr_ctrl_pkg.sv | 24 ++
 rtl/mux4reg_rr_ctrl_rr_pick4.sv | 32 +++
 rtl/mux4reg_rr_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mux4reg_rr_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mux4reg_rr_ctrl_pkg.sv
// Shared definitions for the round-robin registered-mux controller.
//   state_t   : controller FSM encoding (IDLE / CAPTURE / PRESENT)
//   NREQ      : number of requesters sharing the mux
//   SEL_W     : width of the mux select / requester index
//   req_onehot: index -> one-hot requester vector
package mux4reg_rr_ctrl_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    function automatic logic [NREQ-1:0] req_onehot(input logic [SEL_W-1:0] idx);
        logic [NREQ-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/mux4reg_rr_ctrl_rr_pick4.sv
// rr_pick4: combinational round-robin picker for four requesters.
//   req        in  4  request vector (already masked by the caller)
//   last_grant in  2  most recently served requester
//   winner     out 2  first asserted request after last_grant, wrapping 3 -> 0
//   any        out 1  at least one request asserted
module rr_pick4
    import mux4reg_rr_ctrl_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] last_grant,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        // Offsets 1..NREQ; the SEL_W-bit add wraps naturally, and offset NREQ
        // lands back on last_grant so it is considered last.
        for (int i = 1; i <= NREQ; i++) begin
            idx = last_grant + SEL_W'(i);
            if (!any && req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4reg_rr_ctrl.sv
// mux4reg_rr_ctrl: round-robin controller around a registered 4:1 data mux.
// Four requesters share the mux; the winner's word is presented to a single
// consumer with valid/ready, and the winner gets a one-cycle ack on hand-off.
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   req         in   [4] requests, held with stable data until ack
//   in_a..in_d  in   [BITS] requester words 0..3
//   ack         out  [4] one-hot pulse to the served requester
//   select      out  [2] registered mux select
//   out_data    out  [BITS] registered mux output
//   out_valid   out  out_data holds a granted word
//   out_ready   in   consumer accepts when out_valid && out_ready
//   out_src     out  [2] requester index of the word in out_data
//   timeout_err out  one-cycle abort pulse (stall timeout build only)
// Build option: define MUX4REG_CTRL_TIMEOUT_EN to abort a PRESENT that has
// stalled TIMEOUT cycles; otherwise PRESENT waits indefinitely.
module mux4reg_rr_ctrl
    import mux4reg_rr_ctrl_pkg::*;
#(
    parameter int BITS    = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [BITS-1:0]   in_a,
    input  logic [BITS-1:0]   in_b,
    input  logic [BITS-1:0]   in_c,
    input  logic [BITS-1:0]   in_d,
    output logic [NREQ-1:0]   ack,
    output logic [SEL_W-1:0]  select,
    output logic [BITS-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  out_src,
    output logic              timeout_err
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] select_q, select_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;
    logic [BITS-1:0]  out_data_q, out_data_d;

    logic [BITS-1:0]  word [NREQ];
    logic             accept;
    logic             tmo;
    logic             release_w;
    logic [NREQ-1:0]  pick_req;
    logic [SEL_W-1:0] pick_last;
    logic [SEL_W-1:0] winner;
    logic             any;

    assign word[0] = in_a;
    assign word[1] = in_b;
    assign word[2] = in_c;
    assign word[3] = in_d;

    // Registered mux: no enable, holds only because select and data are stable.
    assign out_data_d = word[select_q];

    assign out_valid = (state_q == ST_PRESENT) && !tmo;
    assign accept    = out_valid && out_ready;
    // The served requester is released either by a hand-off or by a timeout.
    assign release_w = accept || tmo;

    // On release, arbitrate as if last_grant were already updated, and hide the
    // requester being acked so a still-high req cannot win again immediately.
    assign pick_req  = release_w ? (req & ~req_onehot(out_src_q)) : req;
    assign pick_last = release_w ? out_src_q : last_grant_q;

    rr_pick4 u_pick (
        .req        (pick_req),
        .last_grant (pick_last),
        .winner     (winner),
        .any        (any)
    );

`ifdef MUX4REG_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tmo = (state_q == ST_PRESENT) && (cnt_q == CNT_W'(TIMEOUT));

    // Held at zero outside PRESENT, so every PRESENT entry starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != ST_PRESENT) begin
            cnt_d = '0;
        end else if (!accept && !tmo) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT;
    assign tmo                = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            select_q     <= '0;
            out_src_q    <= '0;
            last_grant_q <= SEL_W'(NREQ - 1);
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            select_q     <= select_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        select_d     = select_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    select_d  = winner;
                    out_src_d = winner;
                    state_d   = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (release_w) begin
                    last_grant_d = out_src_q;
                    if (any && !tmo) begin
                        select_d  = winner;
                        out_src_d = winner;
                        state_d   = ST_CAPTURE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        ack = '0;
        if (release_w) begin
            ack = req_onehot(out_src_q);
        end
    end

    assign select      = select_q;
    assign out_src     = out_src_q;
    assign out_data    = out_data_q;
    assign timeout_err = tmo;

endmodule

// File: tb/tb_mux4reg_rr_ctrl.sv
module tb_mux4reg_rr_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [2:0] in_a, in_b, in_c, in_d;
    logic [3:0] ack;
    logic [1:0] select;
    logic [2:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_src;
    logic       timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    mux4reg_rr_ctrl #(.BITS(3), .TIMEOUT(15)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_c        (in_c),
        .in_d        (in_d),
        .ack         (ack),
        .select      (select),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_src     (out_src),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] ack;
        logic       valid;
        logic [1:0] sel;
        logic [1:0] src;
        logic       chk_data;
        logic [2:0] data;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // ack must be one-hot-or-zero and only with an accepting handshake.
    always @(negedge clock) begin
        n_cmp++;
        if (!$onehot0(ack) || (ack != 4'b0000 && !(out_valid && out_ready))) begin
            n_bad++;
            $display("FAIL ack_rule: got ack=%b valid=%b ready=%b required one-hot ack only on handshake",
                     ack, out_valid, out_ready);
        end
    end

    initial begin
        // Fairness: all four requesting, grant order 0,1,2,3,0, one word per 2 cycles.
        // Words: a=1 b=6 c=5 d=3.
        vecs[0]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b1, 3'd0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b1, 3'd1};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0, 1'b1, 3'd1};
        vecs[3]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd1, 2'd1, 1'b1, 3'd1};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1, 1'b1, 3'd6};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd2, 2'd2, 1'b1, 3'd6};
        vecs[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2, 1'b1, 3'd5};
        vecs[7]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, 2'd3, 1'b1, 3'd5};
        vecs[8]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3, 1'b1, 3'd3};
        vecs[9]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b1, 3'd3};
        vecs[10] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0, 1'b1, 3'd1};
        // Single request from requester 2 (in_c = 5).
        vecs[11] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b1, 3'd1};
        vecs[12] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 2'd2, 2'd2, 1'b1, 3'd1};
        vecs[13] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2, 1'b1, 3'd5};
        vecs[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 2'd2, 1'b1, 3'd5};

        reset     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        in_a = 3'd0; in_b = 3'd0; in_c = 3'd0; in_d = 3'd0;

        // Reset held
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst.valid", out_valid, 0);
        check("rst.select", select, 0);
        check("rst.data", out_data, 0);
        check("rst.ack", ack, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Released with no requests: everything stays quiet for 10 cycles.
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check("idle.valid", out_valid, 0);
            check("idle.select", select, 0);
            check("idle.src", out_src, 0);
            check("idle.data", out_data, 0);
            check("idle.ack", ack, 0);
            check("idle.tmo", timeout_err, 0);
            next_cycle();
        end
        $display("idle phase: 10 cycles checked");

        in_a = 3'd1; in_b = 3'd6; in_c = 3'd5; in_d = 3'd3;
        for (int i = 0; i < 15; i++) begin
            req       = vecs[i].req;
            out_ready = vecs[i].rdy;
            @(negedge clock);
            $display("vec %0d: req=%b ack=%b valid=%b sel=%0d src=%0d data=%0d",
                     i, req, ack, out_valid, select, out_src, out_data);
            check($sformatf("vec%0d.ack", i), ack, vecs[i].ack);
            check($sformatf("vec%0d.valid", i), out_valid, vecs[i].valid);
            check($sformatf("vec%0d.select", i), select, vecs[i].sel);
            check($sformatf("vec%0d.src", i), out_src, vecs[i].src);
            if (vecs[i].chk_data)
                check($sformatf("vec%0d.data", i), out_data, vecs[i].data);
            next_cycle();
        end

        // Backpressure on requester 1, plus a non-winner request during the stall.
        req = 4'b0010; out_ready = 1'b0;
        @(negedge clock);
        check("bp.idle_valid", out_valid, 0);
        next_cycle();
        @(negedge clock);
        check("bp.cap_select", select, 1);
        check("bp.cap_valid", out_valid, 0);
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            req = (k >= 2) ? 4'b0011 : 4'b0010;
            @(negedge clock);
            $display("bp stall %0d: valid=%b data=%0d ack=%b sel=%0d", k, out_valid, out_data, ack, select);
            check("bp.valid", out_valid, 1);
            check("bp.data", out_data, 6);
            check("bp.ack", ack, 0);
            check("bp.select", select, 1);
            check("bp.src", out_src, 1);
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("bp.release_ack", ack, 4'b0010);
        check("bp.release_data", out_data, 6);
        next_cycle();
        req = 4'b0001;
        @(negedge clock);
        check("b2b.select", select, 0);
        check("b2b.src", out_src, 0);
        check("b2b.valid", out_valid, 0);
        next_cycle();
        @(negedge clock);
        check("b2b.valid2", out_valid, 1);
        check("b2b.data", out_data, 1);
        check("b2b.ack", ack, 4'b0001);
        next_cycle();
        req = 4'b0000;
        @(negedge clock);
        check("b2b.idle", out_valid, 0);
        $display("backpressure sequence done");
        next_cycle();

        // Asynchronous reset while presenting requester 2.
        req = 4'b0100; out_ready = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clock);
        check("ar.present_valid", out_valid, 1);
        check("ar.present_data", out_data, 5);
        #2;
        reset = 1'b0;
        #1;
        check("ar.valid", out_valid, 0);
        check("ar.select", select, 0);
        check("ar.src", out_src, 0);
        check("ar.data", out_data, 0);
        out_ready = 1'b1;
        #1;
        check("ar.ack", ack, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check("ar.held_ack", ack, 0);
            check("ar.held_valid", out_valid, 0);
        end
        req = 4'b0000;
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check("ar.lost_valid", out_valid, 0);
            check("ar.lost_ack", ack, 0);
        end
        $display("async reset sequence done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
